// File: rtl/all_gates.sv
// Registered bank of the eight basic two-input logic functions, evaluated bitwise
// over WIDTH-bit operands, with a one-cycle latency and a per-cycle valid flag.
module all_gates #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] not_out1,
  output logic [WIDTH-1:0] not_out2,
  output logic [WIDTH-1:0] or_out,
  output logic [WIDTH-1:0] and_out,
  output logic [WIDTH-1:0] xor_out,
  output logic [WIDTH-1:0] nor_out,
  output logic [WIDTH-1:0] nand_out,
  output logic [WIDTH-1:0] xnor_out,
  output logic             out_valid
);

  // NOTE: every register below uses non-blocking assignment so all outputs
  // sample the same pre-edge a/b values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      not_out1  <= '0;
      not_out2  <= '0;
      or_out    <= '0;
      and_out   <= '0;
      xor_out   <= '0;
      nor_out   <= '0;
      nand_out  <= '0;
      xnor_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      // out_valid flags a fresh result only; gate outputs hold when en is low
      out_valid <= en;
      if (en) begin
        not_out1 <= ~a;
        not_out2 <= ~b;
        or_out   <= a | b;
        and_out  <= a & b;
        xor_out  <= a ^ b;
        nor_out  <= ~(a | b);
        nand_out <= ~(a & b);
        xnor_out <= ~(a ^ b);
      end
    end
  end

endmodule

// File: tb/tb_all_gates.sv
// Directed bench for all_gates: WIDTH=1, 8 and 16 instances sharing clk/rst,
// each scenario in its own task with inline comparisons.
module tb_all_gates;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // WIDTH=1 instance
  logic       en1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [0:0] n1_1, n2_1, or_1, and_1, xor_1, nor_1, nand_1, xnor_1;
  logic       v1;
  logic [7:0] all1;
  assign all1 = {n1_1, n2_1, or_1, and_1, xor_1, nor_1, nand_1, xnor_1};

  all_gates #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .en(en1), .a(a1), .b(b1),
    .not_out1(n1_1), .not_out2(n2_1), .or_out(or_1), .and_out(and_1),
    .xor_out(xor_1), .nor_out(nor_1), .nand_out(nand_1), .xnor_out(xnor_1),
    .out_valid(v1)
  );

  // WIDTH=8 instance
  logic        en8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  n1_8, n2_8, or_8, and_8, xor_8, nor_8, nand_8, xnor_8;
  logic        v8;
  logic [63:0] all8;
  assign all8 = {n1_8, n2_8, or_8, and_8, xor_8, nor_8, nand_8, xnor_8};

  all_gates #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .en(en8), .a(a8), .b(b8),
    .not_out1(n1_8), .not_out2(n2_8), .or_out(or_8), .and_out(and_8),
    .xor_out(xor_8), .nor_out(nor_8), .nand_out(nand_8), .xnor_out(xnor_8),
    .out_valid(v8)
  );

  // WIDTH=16 instance
  logic        en16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [15:0] n1_16, n2_16, or_16, and_16, xor_16, nor_16, nand_16, xnor_16;
  logic        v16;

  all_gates #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .en(en16), .a(a16), .b(b16),
    .not_out1(n1_16), .not_out2(n2_16), .or_out(or_16), .and_out(and_16),
    .xor_out(xor_16), .nor_out(nor_16), .nand_out(nand_16), .xnor_out(xnor_16),
    .out_valid(v16)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    en8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C;
    step();
    step();
    checks++;
    if (all1 !== 8'h00 || v1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_w1: got %h valid=%b expected 00 valid=0", all1, v1);
    end
    checks++;
    if (all8 !== 64'h0 || v8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_w8: got %h valid=%b expected 0 valid=0", all8, v8);
    end
    en1 = 1'b0; en8 = 1'b0; en16 = 1'b0;
    rst = 1'b0;
    step();
    // no enabled capture yet: inverting outputs still read 0
    checks++;
    if (all1 !== 8'h00 || v1 !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle_w1: got %h valid=%b expected 00 valid=0", all1, v1);
    end
  endtask

  task automatic test_truth_w1();
    logic [1:0] ab [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
    // {not1,not2,or,and,xor,nor,nand,xnor}
    logic [7:0] exp [4] = '{8'b1100_0111, 8'b1010_1010, 8'b0110_1010, 8'b0011_0001};
    for (int i = 0; i < 4; i++) begin
      en1 = 1'b1;
      a1  = ab[i][1];
      b1  = ab[i][0];
      step();
      checks++;
      if (all1 !== exp[i] || v1 !== 1'b1) begin
        failures++;
        $display("FAIL truth_w1 a=%b b=%b: got %b valid=%b expected %b valid=1",
                 ab[i][1], ab[i][0], all1, v1, exp[i]);
      end
    end
    en1 = 1'b0;
  endtask

  task automatic test_w8();
    en8 = 1'b1; a8 = 8'hF0; b8 = 8'hCC;
    step();
    checks++;
    if (all8 !== 64'h0F33_FCC0_3C03_3FC3 || v8 !== 1'b1) begin
      failures++;
      $display("FAIL w8_f0_cc: got %h valid=%b expected 0f33fcc03c033fc3 valid=1", all8, v8);
    end
    en8 = 1'b0;
  endtask

  task automatic test_hold();
    en8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    step();
    checks++;
    if (all8 !== 64'h55AA_FF00_FF00_FF00 || v8 !== 1'b1) begin
      failures++;
      $display("FAIL hold_capture: got %h valid=%b expected 55aaff00ff00ff00 valid=1", all8, v8);
    end
    en8 = 1'b0; a8 = 8'h00; b8 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (all8 !== 64'h55AA_FF00_FF00_FF00 || v8 !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: got %h valid=%b expected 55aaff00ff00ff00 valid=0",
                 i, all8, v8);
      end
    end
  endtask

  task automatic test_async_reset();
    en1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    en8 = 1'b1; a8 = 8'h0F; b8 = 8'h33;
    step();
    checks++;
    if (and_1 !== 1'b1 || v1 !== 1'b1 || or_8 !== 8'h3F) begin
      failures++;
      $display("FAIL pre_async_capture: got and1=%b valid=%b or8=%h expected 1 1 3f",
               and_1, v1, or_8);
    end
    en1 = 1'b0; en8 = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (all1 !== 8'h00 || v1 !== 1'b0) begin
      failures++;
      $display("FAIL async_clear_w1: got %h valid=%b expected 00 valid=0", all1, v1);
    end
    checks++;
    if (all8 !== 64'h0 || v8 !== 1'b0) begin
      failures++;
      $display("FAIL async_clear_w8: got %h valid=%b expected 0 valid=0", all8, v8);
    end
    #1 rst = 1'b0;
    en1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    step();
    checks++;
    if (and_1 !== 1'b1 || v1 !== 1'b1 || all1 !== 8'b0011_0001) begin
      failures++;
      $display("FAIL post_async_capture: got %b valid=%b expected 00110001 valid=1", all1, v1);
    end
    en1 = 1'b0;
  endtask

  task automatic test_sweep_w16();
    logic [15:0] pa, pb;
    logic [127:0] got, exp;
    int errs = 0;
    for (int i = 0; i < 1000; i++) begin
      pa = 16'($urandom);
      pb = 16'($urandom);
      en16 = 1'b1; a16 = pa; b16 = pb;
      step();
      got = {n1_16, n2_16, or_16, and_16, xor_16, nor_16, nand_16, xnor_16};
      exp = {~pa, ~pb, pa | pb, pa & pb, pa ^ pb, ~(pa | pb), ~(pa & pb), ~(pa ^ pb)};
      checks++;
      if (got !== exp || v16 !== 1'b1) begin
        failures++;
        if (errs++ < 5)
          $display("FAIL sweep_w16 a=%h b=%h: got %h valid=%b expected %h valid=1",
                   pa, pb, got, v16, exp);
      end
      checks++;
      if (nor_16 !== ~or_16 || nand_16 !== ~and_16 || xnor_16 !== ~xor_16 ||
          xor_16 !== (or_16 & nand_16)) begin
        failures++;
        if (errs++ < 5)
          $display("FAIL invariants_w16: got or=%h and=%h xor=%h nor=%h nand=%h xnor=%h expected consistent",
                   or_16, and_16, xor_16, nor_16, nand_16, xnor_16);
      end
    end
    en16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_truth_w1();
    test_w8();
    test_hold();
    test_async_reset();
    test_sweep_w16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
